fwd_mux_pipe: RTL and testbench
===============================

FWD_MUX_PIPE -- requirements
Module: fwd_mux_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of each data channel.
REQ-002 SHALL have parameter NUM_IN, default 4, number of input channels (legal range 2..8).
REQ-003 SHALL derive localparam SEL_W = clog2(NUM_IN), minimum 1.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_i  input  NUM_IN*WIDTH  flattened channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port select_i  input  SEL_W  channel index, sampled with valid_i.
REQ-008 SHALL have port valid_i  input  1  upstream offers data_i/select_i.
REQ-009 SHALL have port ready_o  output  1  block can accept a transfer this cycle.
REQ-010 SHALL have port data_o  output  WIDTH  selected, registered data.
REQ-011 SHALL have port valid_o  output  1  data_o holds an undelivered item.
REQ-012 SHALL have port ready_i  input  1  downstream accepts data_o.
REQ-013 SHALL have port err_o  output  1  sticky out-of-range-select flag.
REQ-014 SHALL have port clr_err_i  input  1  synchronous clear of err_o.

Function
REQ-015 SHALL define input transfer as valid_i && ready_o at a rising edge, output transfer as valid_o && ready_i.
REQ-016 SHALL capture, on input transfer, channel select_i of data_i; no combinational path data_i->data_o.
REQ-017 SHALL present a captured item on data_o/valid_o exactly 1 cycle after its input transfer when the output stage is empty or draining.
REQ-018 SHALL contain two storage entries: output register (OUT) and skid register (SKID), each with a valid bit.
REQ-019 SHALL route an accepted item into OUT if OUT is empty or an output transfer occurs the same cycle while SKID is empty; otherwise into SKID.
REQ-020 SHALL, on output transfer with SKID valid, move SKID into OUT in the same edge; a simultaneous input transfer is then impossible because ready_o is low.
REQ-021 SHALL drive ready_o from a register: ready_o = NOT SKID.valid; no combinational dependence on ready_i.
REQ-022 SHALL sustain one transfer per cycle when ready_i is held high, and preserve strict FIFO order across OUT/SKID.
REQ-023 SHALL hold data_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL, for select_i >= NUM_IN on input transfer, capture the last legally selected value (0 if none since reset) and set err_o the following cycle.
REQ-025 SHALL keep err_o set until clr_err_i=1 at a rising edge; if a new out-of-range capture coincides with clr_err_i, err_o SHALL remain 1.
REQ-026 SHALL ignore data_i/select_i whenever valid_i=0 or ready_o=0; no state change.
REQ-027 SHALL never lose or duplicate items; valid_o falls only after an output transfer with SKID empty and no input transfer.

Reset
REQ-028 SHALL, while rst_i=0, asynchronously force valid_o=0, data_o=0, ready_o=1, err_o=0, SKID invalid/zero, last-legal value=0.
REQ-029 SHALL, on rst_i assertion mid-operation, discard OUT and SKID contents without producing a further output transfer.
REQ-030 SHALL accept a transfer on the first rising edge with rst_i=1.

Verification
REQ-031 SHALL cover: NUM_IN=4, ready_i=1, valid_i=1, select_i=2, channel2=0xCAFE0002 -> next cycle data_o=0xCAFE0002, valid_o=1.
REQ-032 SHALL cover: ready_i=0, three items A,B,C offered back-to-back -> A in OUT, B in SKID, ready_o=0 from cycle 3, C held upstream; ready_i=1 -> A,B,C delivered in order, ready_o=1 after B moves to OUT.
REQ-033 SHALL cover: ready_i=1, 16 consecutive items with select 0,1,2,3 repeating -> 16 output transfers in 16 consecutive cycles, values and order exact.
REQ-034 SHALL cover: NUM_IN=3, legal select 1 (0x11), then select 3 -> second output 0x11, err_o=1 next cycle; clr_err_i pulse -> err_o=0.
REQ-035 SHALL cover: rst_i driven low between clock edges with OUT and SKID full -> valid_o=0, ready_o=1, data_o=0 immediately, before next edge.
REQ-036 SHALL cover: WIDTH=8, NUM_IN=8, select 7 -> bits [63:56] delivered; no err_o.

Source files
------------

// File: rtl/fwd_mux_pipe.sv
// N:1 channel mux feeding a two-entry (output + skid) valid/ready pipeline stage.
// Out-of-range selects reuse the last legal value and raise a sticky error flag.
module fwd_mux_pipe #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_IN*WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]        select_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [WIDTH-1:0]        data_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    err_o,
   input  logic                    clr_err_i
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic [WIDTH-1:0] last_legal_q, last_legal_d;
   logic             err_q, err_d;

   logic             in_xfer_s;
   logic             out_xfer_s;
   logic             sel_legal_s;
   logic [WIDTH-1:0] sel_data_s;
   logic [WIDTH-1:0] cap_data_s;

   // ready_o is a pure function of the skid valid register, so it never sees ready_i
   assign in_xfer_s  = valid_i & ~skid_valid_q;
   assign out_xfer_s = out_valid_q & ready_i;

   // Channel mux and legality of the requested select
   always_comb begin
      sel_data_s  = {WIDTH{1'b0}};
      sel_legal_s = (int'(select_i) < NUM_IN);
      for (int k = 0; k < NUM_IN; k++) begin
         if (int'(select_i) == k) begin
            sel_data_s = data_i[k*WIDTH +: WIDTH];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
      if (sel_legal_s) begin
         cap_data_s = sel_data_s;
      end else begin
         cap_data_s = last_legal_q;
      end
   end

   // Next-state for OUT/SKID entries, last-legal value and sticky error
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      last_legal_d = last_legal_q;
      err_d        = err_q;

      // SKID drains into OUT first; no input can arrive then since ready_o is low
      if (out_xfer_s && skid_valid_q) begin
         out_valid_d  = 1'b1;
         out_data_d   = skid_data_q;
         skid_valid_d = 1'b0;
      end else if (in_xfer_s) begin
         if (!out_valid_q || out_xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = cap_data_s;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = cap_data_s;
         end
      end else if (out_xfer_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      if (in_xfer_s && sel_legal_s) begin
         last_legal_d = sel_data_s;
      end else begin
         last_legal_d = last_legal_q;
      end

      // A new illegal capture wins over a simultaneous clear
      if (in_xfer_s && !sel_legal_s) begin
         err_d = 1'b1;
      end else if (clr_err_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= {WIDTH{1'b0}};
         skid_valid_q <= 1'b0;
         skid_data_q  <= {WIDTH{1'b0}};
         last_legal_q <= {WIDTH{1'b0}};
         err_q        <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         last_legal_q <= last_legal_d;
         err_q        <= err_d;
      end
   end

   assign ready_o = ~skid_valid_q;
   assign data_o  = out_data_q;
   assign valid_o = out_valid_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Directed self-checking bench for fwd_mux_pipe: three parameterisations share clock and reset.
module tb_fwd_mux_pipe;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // Instance A: WIDTH=32, NUM_IN=4
   logic [127:0] a_data;
   logic [1:0]   a_sel;
   logic         a_valid, a_ready_o, a_valid_o, a_ready_i, a_err_o, a_clr;
   logic [31:0]  a_data_o;

   // Instance B: WIDTH=32, NUM_IN=3
   logic [95:0]  b_data;
   logic [1:0]   b_sel;
   logic         b_valid, b_ready_o, b_valid_o, b_ready_i, b_err_o, b_clr;
   logic [31:0]  b_data_o;

   // Instance C: WIDTH=8, NUM_IN=8
   logic [63:0]  c_data;
   logic [2:0]   c_sel;
   logic         c_valid, c_ready_o, c_valid_o, c_ready_i, c_err_o, c_clr;
   logic [7:0]   c_data_o;

   fwd_mux_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .data_i(a_data), .select_i(a_sel), .valid_i(a_valid),
      .ready_o(a_ready_o), .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
      .err_o(a_err_o), .clr_err_i(a_clr));

   fwd_mux_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .data_i(b_data), .select_i(b_sel), .valid_i(b_valid),
      .ready_o(b_ready_o), .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
      .err_o(b_err_o), .clr_err_i(b_clr));

   fwd_mux_pipe #(.WIDTH(8), .NUM_IN(8)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .data_i(c_data), .select_i(c_sel), .valid_i(c_valid),
      .ready_o(c_ready_o), .data_o(c_data_o), .valid_o(c_valid_o), .ready_i(c_ready_i),
      .err_o(c_err_o), .clr_err_i(c_clr));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] item_val(int i, int k);
      return 32'hA000_0000 | (i << 8) | k;
   endfunction

   task automatic test_reset();
      #12;
      checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_valid_o); end
      checks++; if (a_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", a_data_o); end
      checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_ready_o); end
      checks++; if (a_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", a_err_o); end
   endtask

   task automatic test_single();
      a_data    = {32'h3333_3333, 32'hCAFE_0002, 32'h1111_1111, 32'h0000_0000};
      a_sel     = 2'd2;
      a_valid   = 1'b1;
      a_ready_i = 1'b1;
      rst       = 1'b1;
      step();
      a_valid = 1'b0;
      checks++; if (a_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", a_valid_o); end
      checks++; if (a_data_o !== 32'hCAFE_0002) begin errors++; $display("FAIL single_data: got %h want cafe0002", a_data_o); end
      step();
      checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", a_valid_o); end
   endtask

   task automatic test_skid();
      a_data    = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      a_ready_i = 1'b0;
      a_valid   = 1'b1;
      a_sel     = 2'd0;
      step();
      checks++; if (a_data_o !== 32'hAAAA_0000 || a_valid_o !== 1'b1) begin errors++; $display("FAIL skid_a_out: got %h/%b want aaaa0000/1", a_data_o, a_valid_o); end
      checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL skid_ready1: got %b want 1", a_ready_o); end
      a_sel = 2'd1;
      step();
      checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL skid_ready2: got %b want 0", a_ready_o); end
      a_sel = 2'd2;
      step();
      checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL skid_ready3: got %b want 0", a_ready_o); end
      checks++; if (a_data_o !== 32'hAAAA_0000 || a_valid_o !== 1'b1) begin errors++; $display("FAIL skid_hold: got %h/%b want aaaa0000/1", a_data_o, a_valid_o); end
      a_ready_i = 1'b1;
      step();
      checks++; if (a_data_o !== 32'hBBBB_0001 || a_valid_o !== 1'b1) begin errors++; $display("FAIL skid_b_out: got %h/%b want bbbb0001/1", a_data_o, a_valid_o); end
      checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL skid_ready4: got %b want 1", a_ready_o); end
      step();
      a_valid = 1'b0;
      checks++; if (a_data_o !== 32'hCCCC_0002 || a_valid_o !== 1'b1) begin errors++; $display("FAIL skid_c_out: got %h/%b want cccc0002/1", a_data_o, a_valid_o); end
      step();
      checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL skid_empty: got %b want 0", a_valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_v;
      a_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 4; k++) a_data[k*32 +: 32] = item_val(i, k);
         a_sel   = 2'(i % 4);
         a_valid = 1'b1;
         exp_v   = item_val(i, i % 4);
         step();
         checks++;
         if (a_valid_o !== 1'b1 || a_data_o !== exp_v || a_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_item%0d: got %h/v%b/r%b want %h/v1/r1", i, a_data_o, a_valid_o, a_ready_o, exp_v);
         end
      end
      a_valid = 1'b0;
      step();
      checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", a_valid_o); end
   endtask

   task automatic test_err();
      b_ready_i = 1'b1;
      b_data    = {32'h0000_0012, 32'h0000_0011, 32'h0000_0010};
      b_sel     = 2'd1;
      b_valid   = 1'b1;
      step();
      checks++; if (b_data_o !== 32'h11 || b_err_o !== 1'b0) begin errors++; $display("FAIL err_legal: got %h/e%b want 11/e0", b_data_o, b_err_o); end
      b_data = {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD};
      b_sel  = 2'd3;
      step();
      b_valid = 1'b0;
      checks++; if (b_data_o !== 32'h11 || b_valid_o !== 1'b1) begin errors++; $display("FAIL err_lastlegal: got %h/v%b want 11/v1", b_data_o, b_valid_o); end
      checks++; if (b_err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", b_err_o); end
      b_clr = 1'b1;
      step();
      b_clr = 1'b0;
      checks++; if (b_err_o !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", b_err_o); end
      b_valid = 1'b1;
      b_clr   = 1'b1;
      step();
      b_valid = 1'b0;
      b_clr   = 1'b0;
      checks++; if (b_err_o !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", b_err_o); end
      step();
      checks++; if (b_err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", b_err_o); end
      b_clr = 1'b1;
      step();
      b_clr = 1'b0;
      checks++; if (b_err_o !== 1'b0) begin errors++; $display("FAIL err_clear2: got %b want 0", b_err_o); end
   endtask

   task automatic test_wide_sel();
      c_ready_i = 1'b1;
      c_data    = 64'h1716_1514_1312_1110;
      c_sel     = 3'd7;
      c_valid   = 1'b1;
      step();
      c_valid = 1'b0;
      checks++; if (c_data_o !== 8'h17 || c_valid_o !== 1'b1) begin errors++; $display("FAIL sel7_data: got %h/v%b want 17/v1", c_data_o, c_valid_o); end
      checks++; if (c_err_o !== 1'b0) begin errors++; $display("FAIL sel7_err: got %b want 0", c_err_o); end
   endtask

   task automatic test_reset_mid();
      a_data    = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
      a_ready_i = 1'b0;
      a_valid   = 1'b1;
      a_sel     = 2'd0;
      step();
      a_sel = 2'd1;
      step();
      a_valid = 1'b0;
      checks++; if (a_ready_o !== 1'b0 || a_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_full: got r%b/v%b want r0/v1", a_ready_o, a_valid_o); end
      #3;
      rst = 1'b0;
      #1;
      checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", a_valid_o); end
      checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", a_ready_o); end
      checks++; if (a_data_o !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", a_data_o); end
      #2;
      rst       = 1'b1;
      a_ready_i = 1'b1;
      step();
      checks++; if (a_valid_o !== 1'b0 || a_data_o !== 32'h0) begin errors++; $display("FAIL rstmid_nostale: got %h/v%b want 0/v0", a_data_o, a_valid_o); end
      a_valid = 1'b1;
      a_sel   = 2'd2;
      step();
      a_valid = 1'b0;
      checks++; if (a_valid_o !== 1'b1 || a_data_o !== 32'h4444_0002) begin errors++; $display("FAIL rstmid_resume: got %h/v%b want 44440002/v1", a_data_o, a_valid_o); end
   endtask

   initial begin
      a_data = '0; a_sel = '0; a_valid = 1'b0; a_ready_i = 1'b0; a_clr = 1'b0;
      b_data = '0; b_sel = '0; b_valid = 1'b0; b_ready_i = 1'b0; b_clr = 1'b0;
      c_data = '0; c_sel = '0; c_valid = 1'b0; c_ready_i = 1'b0; c_clr = 1'b0;
      test_reset();
      test_single();
      test_skid();
      test_back_to_back();
      test_err();
      test_wide_sel();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
